// File: rtl/vector_sub_arbiter.sv
// vector_sub_arbiter: round-robin shared element-wise vector subtractor with valid/ready handshakes
module vector_sub_arbiter #(
  parameter int WIDTH = 32,
  parameter int LEN   = 8,
  parameter int NREQ  = 4,
  localparam int IDW  = ($clog2(NREQ) < 1) ? 1 : $clog2(NREQ)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NREQ-1:0]                        req_valid,
  output logic [NREQ-1:0]                        req_ready,
  input  logic [NREQ-1:0][LEN-1:0][WIDTH-1:0]    req_a,
  input  logic [NREQ-1:0][LEN-1:0][WIDTH-1:0]    req_b,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [LEN-1:0][WIDTH-1:0]              out_diff,
  output logic [IDW-1:0]                         out_id,
  output logic                                   busy,
  output logic [15:0]                            ops_done
);
  typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;
  state_t                   r_state, w_next;
  logic [LEN-1:0][WIDTH-1:0] r_a, r_b, r_diff;
  logic [IDW-1:0]           r_id, r_last, r_out_id, w_grant, w_idx;
  logic                     w_found;
  logic [15:0]              r_ops_done;
  // first valid requester after the last grant, wrapping around
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IDW'((int'(r_last) + k) % NREQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end
  // next state and handshake outputs
  always_comb begin
    w_next    = r_state == IDLE ? (w_found ? EXEC : IDLE) :
                r_state == EXEC ? OUT : (out_ready ? IDLE : OUT);
    req_ready = (r_state == IDLE && w_found) ? NREQ'(1) << w_grant : '0;
  end
  // state, operand capture, subtraction and completion count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last     <= IDW'(NREQ - 1);
      r_diff     <= '0;
      r_out_id   <= '0;
      r_ops_done <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_found) begin
        r_a    <= req_a[w_grant];
        r_b    <= req_b[w_grant];
        r_id   <= w_grant;
        r_last <= w_grant;
      end
      if (r_state == EXEC) begin
        for (int i = 0; i < LEN; i++) r_diff[i] <= r_a[i] + (~r_b[i] + WIDTH'(1));
        r_out_id <= r_id;
      end
      if (r_state == OUT && out_ready) r_ops_done <= r_ops_done + 16'd1;
    end
  end
  assign out_valid = r_state == OUT;
  assign busy      = r_state != IDLE;
  assign out_diff  = r_diff;
  assign out_id    = r_out_id;
  assign ops_done  = r_ops_done;
endmodule

// File: tb/tb_vector_sub_arbiter.sv
// tb_vector_sub_arbiter: directed checks of grant, arithmetic, backpressure, reset and counter wrap
module tb_vector_sub_arbiter;
  localparam int W = 32, L = 8, N = 4;
  logic clk = 1'b0, rst, out_ready, out_valid, busy;
  logic [N-1:0] req_valid, req_ready;
  logic [N-1:0][L-1:0][W-1:0] req_a, req_b;
  logic [L-1:0][W-1:0] out_diff;
  logic [1:0] out_id;
  logic [15:0] ops_done;
  int passes = 0, total = 0;

  vector_sub_arbiter #(.WIDTH(W), .LEN(L), .NREQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_id(out_id), .busy(busy), .ops_done(ops_done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ops", ops_done, 0);
    chk("rst_id", out_id, 0);
    chk("rst_ready", req_ready, 0);
    for (int i = 0; i < L; i++) chk("rst_diff", out_diff[i], 0);
    // single request from requester 1
    for (int i = 0; i < L; i++) begin req_a[1][i] = 32'(100 + i); req_b[1][i] = 32'd3; end
    req_valid = 4'b0010;
    #1;
    chk("t1_ready", req_ready, 4'b0010);
    step();
    req_valid = '0;
    #1;
    chk("t1_exec_ready", req_ready, 0);
    chk("t1_exec_busy", busy, 1);
    chk("t1_exec_valid", out_valid, 0);
    step();
    chk("t1_out_valid", out_valid, 1);
    for (int i = 0; i < L; i++) chk("t1_diff", out_diff[i], 64'(97 + i));
    chk("t1_id", out_id, 1);
    chk("t1_ops_before", ops_done, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t1_ops", ops_done, 1);
    chk("t1_idle_valid", out_valid, 0);
    // wrap-around arithmetic from requester 0, then backpressure
    req_a[0][0] = 32'h0;        req_b[0][0] = 32'h1;
    req_a[0][1] = 32'h80000000; req_b[0][1] = 32'h1;
    for (int i = 2; i < L; i++) begin req_a[0][i] = 32'd5; req_b[0][i] = 32'd7; end
    req_valid = 4'b0001;
    #1;
    chk("t2_ready", req_ready, 4'b0001);
    step();
    req_valid = 4'b1111;
    step();
    chk("t2_diff0", out_diff[0], 32'hFFFFFFFF);
    chk("t2_diff1", out_diff[1], 32'h7FFFFFFF);
    for (int i = 2; i < L; i++) chk("t2_diffn", out_diff[i], 32'hFFFFFFFE);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", req_ready, 0);
      chk("bp_diff0", out_diff[0], 32'hFFFFFFFF);
      chk("bp_id", out_id, 0);
      chk("bp_ops", ops_done, 1);
      step();
    end
    out_ready = 1'b1; req_valid = '0;
    step();
    out_ready = 1'b0;
    chk("bp_ops_done", ops_done, 2);
    // reset while in EXEC
    req_valid = 4'b0100;
    #1;
    chk("rm_ready", req_ready, 4'b0100);
    step();
    chk("rm_busy_exec", busy, 1);
    rst = 1'b1; req_valid = '0;
    step();
    rst = 1'b0;
    chk("rm_busy", busy, 0);
    chk("rm_valid", out_valid, 0);
    chk("rm_ops", ops_done, 0);
    for (int i = 0; i < L; i++) chk("rm_diff", out_diff[i], 0);
    // round-robin with all requesters valid
    for (int r = 0; r < N; r++)
      for (int i = 0; i < L; i++) begin req_a[r][i] = 32'(1000 + 16 * r + i); req_b[r][i] = 32'(r); end
    req_valid = 4'b1111; out_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_grant", req_ready, 64'(4'b0001 << (k % N)));
      step();
      chk("rr_exec_ready", req_ready, 0);
      step();
      chk("rr_valid", out_valid, 1);
      chk("rr_id", out_id, 64'(k % N));
      chk("rr_diff0", out_diff[0], 64'(1000 + 15 * (k % N)));
      step();
    end
    req_valid = '0; out_ready = 1'b0;
    #1;
    chk("rr_ops", ops_done, 5);
    // counter wrap
    req_valid = 4'b0010;
    #1;
    chk("cw_ready", req_ready, 4'b0010);
    step();
    req_valid = '0;
    step();
    force dut.r_ops_done = 16'hFFFF;
    #1;
    release dut.r_ops_done;
    #1;
    chk("cw_forced", ops_done, 16'hFFFF);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("cw_wrap", ops_done, 16'h0000);
    chk("cw_idle", busy, 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
